branch_update_queue: RTL and testbench
======================================

Name: branch_update_queue

Overview:
- In-order tracker for in-flight conditional branches, sitting between the fetch-stage predictors and the execute-stage branch resolver.
- At fetch, it stores each branch's PC, global history, the three component predictions (gshare, bimodal, local) and the chooser's final choice.
- At resolve, it retires the head entry and sequences one update to the predictor tables and the chooser (write enable, outcome and the original component predictions).
- On a misprediction, it flags a redirect and squashes all younger wrong-path entries.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of two, 2..16.
- PC_WIDTH, 16, width of the stored branch PC.
- HIST_WIDTH, 8, width of the stored global-history snapshot.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- alloc_valid  in  1  fetch presents a predicted branch.
- alloc_ready  out  1  queue accepts an allocation this cycle.
- alloc_pc  in  PC_WIDTH  branch PC.
- alloc_ghist  in  HIST_WIDTH  global history used for the gshare lookup.
- alloc_gshare_pred / alloc_bimodal_pred / alloc_local_pred  in  1 each  component predictions.
- alloc_choice  in  1  chooser's final prediction.
- resolve_valid  in  1  execute resolves the oldest branch.
- resolve_taken  in  1  actual outcome.
- resolve_ready  out  1  queue non-empty and in RUN.
- upd_valid  out  1  one-cycle write enable to predictors and chooser.
- upd_pc  out  PC_WIDTH  update PC.
- upd_ghist  out  HIST_WIDTH  update history.
- upd_outcome  out  1  actual outcome.
- upd_gshare_pred / upd_bimodal_pred / upd_local_pred  out  1 each  original component predictions, for chooser ranking.
- mispredict  out  1  one-cycle redirect pulse.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
  - Port names are clk and reset; reset low clears all state immediately.
- Reset values:
  - count=0, head=tail=0, state=RUN, alloc_ready=1, resolve_ready=0.
  - upd_valid=0, mispredict=0, all upd_* data=0.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Allocation:
  - Handshakes are valid/ready; a transfer occurs when both are high at a rising edge.
  - alloc_ready = (state==RUN) && (count<DEPTH). There is no full-bypass: a simultaneous resolve does not free a slot for an alloc in the same cycle.
- Resolve:
  - resolve_ready = (state==RUN) && (count!=0).
  - resolve_valid while resolve_ready=0 is ignored, with no state change.
- Update latency: 1 cycle.
  - On an accepted resolve at edge N, upd_valid is high for exactly the cycle after N.
  - upd_* carry the head entry's fields and upd_outcome=resolve_taken.
  - The head entry is popped at edge N.
- Misprediction:
  - Condition: resolve_taken != head alloc_choice; mispredict pulses together with upd_valid.
  - At edge N, all remaining entries are discarded: count→0, tail←head+1.
  - An alloc accepted in the same cycle is also discarded (wrong path).
  - State→FLUSH.
- FSM:
  - RUN: normal operation.
  - FLUSH: one cycle; alloc_ready=0, resolve_ready=0, then →RUN.
  - No other states; reset from any state → RUN.
- Correct prediction with simultaneous alloc: push and pop both occur, and count is unchanged.
- Counting: count increments and decrements by at most 1 per cycle, except on mispredict, where it clears to 0.

Optional Feature:
- Macro: BUQ_STATS_EN.
- With the macro defined:
  - Extra outputs stat_resolved [15:0] and stat_mispred [15:0].
  - stat_resolved increments on every accepted resolve; stat_mispred increments on every mispredict.
  - Both saturate at 16'hFFFF and reset to 0.
- Without the macro: the ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset, then allocate PCs 0x10, 0x20, 0x30, 0x40 with choice=1 → count=4 and alloc_ready=0; a 5th alloc is not accepted.
- From a full queue, resolve taken=1 four times → four upd_valid pulses with upd_pc 0x10..0x40 in order, mispredict=0, and count ends at 0 with resolve_ready=0.
- Three entries held (head choice=1); resolve taken=0 while alloc_valid=1 → next cycle upd_valid=1, mispredict=1, upd_outcome=0; count=0; alloc_ready=0 for one cycle, then 1.
- One entry held; alloc and correct resolve in the same cycle → count stays 1 and upd_pc equals the old head.
- Assert reset mid-stream with count=3 → all outputs return to reset values asynchronously, before the next edge.
- With BUQ_STATS_EN defined, run 5 resolves including 2 mispredicts → stat_resolved=5, stat_mispred=2.

Source files
------------

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight conditional branches: captures predictor state at fetch,
// emits one predictor/chooser update per resolve and flushes wrong-path entries on mispredict.
// Optional BUQ_STATS_EN adds saturating resolve/mispredict counters.
//
// state | meaning
// RUN   | normal alloc/resolve operation
// FLUSH | one bubble after a mispredict; no handshakes accepted
module branch_update_queue #(
    parameter int DEPTH      = 4,
    parameter int PC_WIDTH   = 16,
    parameter int HIST_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [PC_WIDTH-1:0]          alloc_pc,
    input  logic [HIST_WIDTH-1:0]        alloc_ghist,
    input  logic                         alloc_gshare_pred,
    input  logic                         alloc_bimodal_pred,
    input  logic                         alloc_local_pred,
    input  logic                         alloc_choice,
    input  logic                         resolve_valid,
    input  logic                         resolve_taken,
    output logic                         resolve_ready,
    output logic                         upd_valid,
    output logic [PC_WIDTH-1:0]          upd_pc,
    output logic [HIST_WIDTH-1:0]        upd_ghist,
    output logic                         upd_outcome,
    output logic                         upd_gshare_pred,
    output logic                         upd_bimodal_pred,
    output logic                         upd_local_pred,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef BUQ_STATS_EN
    ,
    output logic [15:0]                  stat_resolved,
    output logic [15:0]                  stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state_q, state_d;

    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];
    logic [HIST_WIDTH-1:0] hist_mem [DEPTH];
    logic [3:0]            pred_mem [DEPTH];  // {gshare, bimodal, local, choice}

    logic [PTR_W-1:0] head, tail;
    logic             alloc_fire, resolve_fire, mispred_now;

    always_comb begin
        state_d       = state_q;
        alloc_ready   = (state_q == RUN) && (count < CNT_W'(DEPTH));
        resolve_ready = (state_q == RUN) && (count != '0);
        alloc_fire    = alloc_valid && alloc_ready;
        resolve_fire  = resolve_valid && resolve_ready;
        mispred_now   = resolve_fire && (resolve_taken != pred_mem[head][0]);
        case (state_q)
            RUN:     if (mispred_now) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                hist_mem[i] <= '0;
                pred_mem[i] <= '0;
            end
        end else if (alloc_fire && !mispred_now) begin
            pc_mem[tail]   <= alloc_pc;
            hist_mem[tail] <= alloc_ghist;
            pred_mem[tail] <= {alloc_gshare_pred, alloc_bimodal_pred, alloc_local_pred, alloc_choice};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            upd_valid        <= 1'b0;
            mispredict       <= 1'b0;
            upd_pc           <= '0;
            upd_ghist        <= '0;
            upd_outcome      <= 1'b0;
            upd_gshare_pred  <= 1'b0;
            upd_bimodal_pred <= 1'b0;
            upd_local_pred   <= 1'b0;
        end else begin
            upd_valid  <= resolve_fire;
            mispredict <= mispred_now;
            if (resolve_fire) begin
                upd_pc           <= pc_mem[head];
                upd_ghist        <= hist_mem[head];
                upd_outcome      <= resolve_taken;
                upd_gshare_pred  <= pred_mem[head][3];
                upd_bimodal_pred <= pred_mem[head][2];
                upd_local_pred   <= pred_mem[head][1];
                head             <= head + 1'b1;
            end
            // A mispredict drops every younger entry, including a same-cycle alloc.
            if (mispred_now) begin
                count <= '0;
                tail  <= head + 1'b1;
            end else begin
                if (alloc_fire) tail <= tail + 1'b1;
                if (alloc_fire && !resolve_fire)      count <= count + 1'b1;
                else if (!alloc_fire && resolve_fire) count <= count - 1'b1;
            end
        end
    end

`ifdef BUQ_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (resolve_fire && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 1'b1;
            if (mispred_now && stat_mispred != 16'hFFFF)   stat_mispred  <= stat_mispred + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: directed scenarios plus randomized traffic against a
// queue-based reference model. Define BUQ_STATS_EN to also check the statistics counters.
module tb_branch_update_queue;

    localparam int DEPTH = 4;

    logic        clk, reset;
    logic        alloc_valid, alloc_ready;
    logic [15:0] alloc_pc;
    logic [7:0]  alloc_ghist;
    logic        alloc_gshare_pred, alloc_bimodal_pred, alloc_local_pred, alloc_choice;
    logic        resolve_valid, resolve_taken, resolve_ready;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic [7:0]  upd_ghist;
    logic        upd_outcome, upd_gshare_pred, upd_bimodal_pred, upd_local_pred;
    logic        mispredict;
    logic [2:0]  count;
`ifdef BUQ_STATS_EN
    logic [15:0] stat_resolved, stat_mispred;
`endif

    branch_update_queue #(.DEPTH(DEPTH), .PC_WIDTH(16), .HIST_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_pc(alloc_pc), .alloc_ghist(alloc_ghist),
        .alloc_gshare_pred(alloc_gshare_pred), .alloc_bimodal_pred(alloc_bimodal_pred),
        .alloc_local_pred(alloc_local_pred), .alloc_choice(alloc_choice),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghist(upd_ghist), .upd_outcome(upd_outcome),
        .upd_gshare_pred(upd_gshare_pred), .upd_bimodal_pred(upd_bimodal_pred),
        .upd_local_pred(upd_local_pred), .mispredict(mispredict), .count(count)
`ifdef BUQ_STATS_EN
        , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  gh;
        logic        g, b, l, c;
    } ent_t;

    ent_t        mq[$];
    bit          m_flush;
    bit          e_uv, e_mp;
    logic [15:0] e_pc;
    logic [7:0]  e_gh;
    logic        e_out, e_g, e_b, e_l;
    logic [15:0] m_res, m_mis;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        m_flush = 0; e_uv = 0; e_mp = 0;
        m_res = '0; m_mis = '0;
    endfunction

    function automatic void model_step();
        bit   a_ok, r_ok;
        ent_t e, n;
        a_ok = alloc_valid && !m_flush && (mq.size() < DEPTH);
        r_ok = resolve_valid && !m_flush && (mq.size() > 0);
        m_flush = 0;
        e_uv = r_ok;
        e_mp = 0;
        if (r_ok) begin
            e = mq.pop_front();
            e_pc = e.pc; e_gh = e.gh; e_g = e.g; e_b = e.b; e_l = e.l;
            e_out = resolve_taken;
            e_mp = (resolve_taken != e.c);
            if (m_res != 16'hFFFF) m_res++;
            if (e_mp && m_mis != 16'hFFFF) m_mis++;
        end
        if (e_mp) begin
            mq.delete();
            m_flush = 1;
        end else if (a_ok) begin
            n.pc = alloc_pc; n.gh = alloc_ghist;
            n.g = alloc_gshare_pred; n.b = alloc_bimodal_pred; n.l = alloc_local_pred; n.c = alloc_choice;
            mq.push_back(n);
        end
    endfunction

    task automatic check_all();
        chk("count", 32'(count), mq.size());
        chk("alloc_ready", alloc_ready, !m_flush && (mq.size() < DEPTH));
        chk("resolve_ready", resolve_ready, !m_flush && (mq.size() > 0));
        chk("upd_valid", upd_valid, e_uv);
        chk("mispredict", mispredict, e_mp);
        if (e_uv) begin
            chk("upd_pc", upd_pc, e_pc);
            chk("upd_ghist", upd_ghist, e_gh);
            chk("upd_outcome", upd_outcome, e_out);
            chk("upd_preds", {upd_gshare_pred, upd_bimodal_pred, upd_local_pred}, {e_g, e_b, e_l});
        end
`ifdef BUQ_STATS_EN
        chk("stat_resolved", stat_resolved, m_res);
        chk("stat_mispred", stat_mispred, m_mis);
`endif
    endtask

    // Called at a falling edge: drive, update model, advance one cycle, check.
    task automatic cycle(input bit av, input logic [15:0] pc, input bit c, input bit rv, input bit rt);
        alloc_valid        = av;
        alloc_pc           = pc;
        alloc_ghist        = 8'($urandom);
        alloc_gshare_pred  = 1'($urandom);
        alloc_bimodal_pred = 1'($urandom);
        alloc_local_pred   = 1'($urandom);
        alloc_choice       = c;
        resolve_valid      = rv;
        resolve_taken      = rt;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_pc = '0; alloc_ghist = '0;
        alloc_gshare_pred = 0; alloc_bimodal_pred = 0; alloc_local_pred = 0; alloc_choice = 0;
        resolve_valid = 0; resolve_taken = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1;
        check_all();
        chk("rst_upd_pc", upd_pc, 16'h0);
        chk("rst_upd_ghist", upd_ghist, 8'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          av, rv, rt, c;
        logic [15:0] pc;
        reset = 1;
        idle_inputs();
        @(negedge clk);
        apply_reset();

        // Fill to capacity; fifth alloc must bounce.
        for (int i = 0; i < 4; i++) cycle(1, 16'(16'h10 * (i + 1)), 1, 0, 0);
        chk("full_count", 32'(count), 4);
        chk("full_alloc_ready", alloc_ready, 1'b0);
        cycle(1, 16'h50, 1, 0, 0);
        chk("full_no_5th", 32'(count), 4);

        // Drain with correct predictions.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 16'h0, 0, 1, 1);
            chk("drain_pc", upd_pc, 16'(16'h10 * (i + 1)));
            chk("drain_nomis", mispredict, 1'b0);
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_resolve_ready", resolve_ready, 1'b0);

        // Mispredict with a same-cycle alloc on the wrong path.
        for (int i = 0; i < 3; i++) cycle(1, 16'(16'h100 + i), 1, 0, 0);
        cycle(1, 16'h999, 1, 1, 0);
        chk("mp_upd_valid", upd_valid, 1'b1);
        chk("mp_pulse", mispredict, 1'b1);
        chk("mp_outcome", upd_outcome, 1'b0);
        chk("mp_count", 32'(count), 0);
        chk("mp_flush_ready", alloc_ready, 1'b0);
        cycle(0, 16'h0, 0, 0, 0);
        chk("mp_run_ready", alloc_ready, 1'b1);
        chk("mp_pulse_end", mispredict, 1'b0);

        // Simultaneous alloc and correct resolve keeps occupancy.
        cycle(1, 16'h111, 1, 0, 0);
        cycle(1, 16'h222, 1, 1, 1);
        chk("pushpop_count", 32'(count), 1);
        chk("pushpop_pc", upd_pc, 16'h111);

        // Async reset mid-stream with three entries and an update pulse in flight.
        cycle(1, 16'h333, 0, 0, 0);
        cycle(1, 16'h444, 1, 0, 0);
        cycle(1, 16'h555, 1, 1, 1);
        chk("pre_rst_count", 32'(count), 3);
        chk("pre_rst_uv", upd_valid, 1'b1);
        idle_inputs();
        #1 reset = 0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_alloc_ready", alloc_ready, 1'b1);
        chk("arst_resolve_ready", resolve_ready, 1'b0);
        chk("arst_upd_valid", upd_valid, 1'b0);
        chk("arst_mispredict", mispredict, 1'b0);
        chk("arst_upd_pc", upd_pc, 16'h0);
        @(negedge clk);
        apply_reset();

`ifdef BUQ_STATS_EN
        for (int k = 0; k < 5; k++) begin
            cycle(1, 16'(16'h700 + k), 1, 0, 0);
            cycle(0, 16'h0, 0, 1, (k == 1 || k == 3) ? 1'b0 : 1'b1);
            cycle(0, 16'h0, 0, 0, 0);
        end
        chk("stats_resolved5", stat_resolved, 16'd5);
        chk("stats_mispred2", stat_mispred, 16'd2);
`endif

        // Randomized traffic; taken is biased toward the head's choice to build occupancy.
        repeat (500) begin
            av = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 9) < 5);
            pc = 16'($urandom);
            c  = 1'($urandom);
            rt = 1'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) rt = mq[0].c;
            cycle(av, pc, c, rv, rt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
